// File: rtl/mips_pkg.sv
// Shared MIPS definitions: register-bank geometry and the debug dump FSM encoding.
package mips_pkg;

  localparam int unsigned MIPS_NREGS = 32;
  localparam int unsigned MIPS_AW    = 5;
  localparam int unsigned MIPS_DW    = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// Walks every register through the bank's spare read port and streams (index, data) words
// over a valid/ready handshake, holding off register writes while the walk is in progress.
module reg_dump
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = MIPS_NREGS,
  parameter int unsigned AW    = MIPS_AW,
  parameter int unsigned DW    = MIPS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          hold_wr,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_t   state;
  logic [AW-1:0] idx;

  assign busy    = (state != IDLE);
  assign hold_wr = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      ra        <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            ra    <= '0;
            state <= READ;
          end
        end
        READ: begin
          // The bank read is combinational, so rd already reflects ra this cycle.
          out_data  <= rd;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              ra    <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dumps, back-pressure, held start, async reset, write hold,
// and a 4-register build, all checked against a preloaded bank model.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic [4:0]  ra, ra4;
  logic [31:0] rd, rd4;
  logic        out_valid, out_valid4;
  logic        out_ready, out_ready4;
  logic [31:0] out_data, out_data4;
  logic [4:0]  out_idx, out_idx4;
  logic        busy, busy4, hold_wr, hold_wr4, done, done4;

  logic        preload, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] bank [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_dump dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .hold_wr(hold_wr), .done(done)
  );

  reg_dump #(.NREGS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ra(ra4), .rd(rd4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_idx(out_idx4),
    .busy(busy4), .hold_wr(hold_wr4), .done(done4)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h1111_1111;
  endfunction

  // Bank model with control-path write gating.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
    end else if (we && !hold_wr) begin
      bank[wa] <= wd;
    end
  end

  assign rd  = bank[ra];
  assign rd4 = bank[ra4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full dump from IDLE; exp_done = 0 skips the exact done-cycle check.
  task automatic do_dump(input bit rnd, input bit wr_attempt, input int exp_done);
    int cyc, nwords, done_cyc;
    bit first_seen;
    nwords = 0; done_cyc = 0; first_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("read_busy", {31'd0, busy}, 32'd1);
    check("read_hold_wr", {31'd0, hold_wr}, 32'd1);
    check("read_ra", {27'd0, ra}, 32'd0);
    check("read_valid", {31'd0, out_valid}, 32'd0);
    while (cyc < 600 && done_cyc == 0) begin
      if (wr_attempt) begin
        we = (cyc >= 3 && cyc < 6);
        wa = 5'd5;
        wd = 32'hDEAD_BEEF;
      end
      if (done) done_cyc = cyc;
      if (out_valid) begin
        if (!first_seen) check("first_valid_cycle", cyc, 32'd2);
        first_seen = 1;
        check("word_idx", {27'd0, out_idx}, nwords);
        check("word_data", out_data, init_val(nwords));
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) nwords++;
      end
      if (done_cyc == 0) begin
        tick();
        cyc++;
      end
    end
    we = 1'b0;
    check("done_seen", {31'd0, done_cyc != 0}, 32'd1);
    if (exp_done != 0) check("done_cycle", done_cyc, exp_done);
    check("word_count", nwords, 32'd32);
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_hold_wr", {31'd0, hold_wr}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc, dones, words;
    bit found;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b1;
    preload = 1'b1; we = 1'b0; wa = '0; wd = '0;
    tick();
    tick();
    preload = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hold_wr", {31'd0, hold_wr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_idx", {27'd0, out_idx}, 32'd0);
    check("rst_ra", {27'd0, ra}, 32'd0);
    rst = 1'b0;
    tick();

    // Full dump with ready always high: done lands in cycle 65.
    do_dump(1'b0, 1'b0, 65);
    // Back-pressure: words stay stable while stalled, none lost or duplicated.
    do_dump(1'b1, 1'b0, 0);
    // Write to reg 5 attempted mid-dump is held off by hold_wr.
    do_dump(1'b0, 1'b1, 65);
    check("bank5_unchanged", bank[5], init_val(5));

    // Held start: one dump, then a second one from the first IDLE cycle.
    out_ready = 1'b1;
    dones = 0; words = 0;
    start = 1'b1;
    tick();
    cyc = 1;
    while (cyc <= 100) begin
      if (done) dones++;
      if (out_valid && out_ready) words++;
      if (cyc == 66) check("held_idle_gap", {31'd0, busy}, 32'd0);
      if (cyc == 67) begin
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        check("held_restart_ra", {27'd0, ra}, 32'd0);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    while (cyc < 300 && dones < 2) begin
      if (done) dones++;
      if (out_valid && out_ready) words++;
      if (dones < 2) begin
        tick();
        cyc++;
      end
    end
    check("held_dones", dones, 32'd2);
    check("held_words", words, 32'd64);
    check("held_done_cycle", cyc, 32'd131);
    tick();
    check("held_no_third", {31'd0, busy}, 32'd0);

    // Async reset while stalled in SEND at index 7.
    found = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_idx == 5'd7) begin
        found = 1;
        out_ready = 1'b0;
      end else begin
        tick();
      end
    end
    check("reached_idx7", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_hold_wr", {31'd0, hold_wr}, 32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_data", out_data, 32'd0);
    check("async_idx", {27'd0, out_idx}, 32'd0);
    check("async_ra", {27'd0, ra}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("aborted_no_done", {31'd0, done}, 32'd0);
    end
    do_dump(1'b0, 1'b0, 65);

    // 4-register build.
    words = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 1;
    while (cyc < 50 && !done4) begin
      if (out_valid4) begin
        check("n4_idx", {27'd0, out_idx4}, words);
        check("n4_data", out_data4, init_val(words));
        words++;
      end
      tick();
      cyc++;
    end
    check("n4_done", {31'd0, done4}, 32'd1);
    check("n4_words", words, 32'd4);
    check("n4_done_cycle", cyc, 32'd9);
    tick();
    check("n4_idle", {31'd0, busy4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
